// File: rtl/sar_ctrl_pkg.sv
// rtl/sar_ctrl_pkg.sv - state encoding and flag helper for sar_compare_ctrl
package sar_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic onehot3(input logic lt, input logic eq, input logic gt);
    return (lt & ~eq & ~gt) | (~lt & eq & ~gt) | (~lt & ~eq & gt);
  endfunction

endpackage

// File: rtl/sar_compare_ctrl.sv
// rtl/sar_compare_ctrl.sv - successive-approximation controller driving an external comparator
// Optional: SAR_EARLY_EXIT_EN ends the search on the first one-hot exact match.
module sar_compare_ctrl #(
  parameter  int WIDTH = 4,
  localparam int SW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [SW-1:0]    steps,
  output logic             err
);
  import sar_ctrl_pkg::*;

  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nx;
  logic [WIDTH-1:0] r_trial;
  logic [WIDTH-1:0] r_mask;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [SW-1:0]    r_steps;
  logic             r_err;

  logic             w_onehot;
  logic             w_keep;
  logic             w_last;
  logic             w_hit;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_mask_nx;
  logic             w_accept;

  assign w_onehot  = onehot3(cmp_lt, cmp_eq, cmp_gt);
  assign w_keep    = (cmp_lt | cmp_eq) & ~cmp_gt;
  // The accumulated code is always trial with the current mask bit removed or kept.
  assign w_acc_nx  = w_keep ? r_trial : (r_trial & ~r_mask);
  assign w_mask_nx = r_mask >> 1;
  assign w_last    = r_mask[0];
  assign w_accept  = start & ~abort;

`ifdef SAR_EARLY_EXIT_EN
  assign w_hit = cmp_eq & w_onehot;
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nx = ST_CMP;
      ST_CMP: begin
        if (abort) begin
          w_state_nx = ST_IDLE;
        end else if (w_hit || w_last) begin
          w_state_nx = ST_DONE;
        end
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_CMP);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trial  <= '0;
      r_mask   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_steps  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_trial <= MSB_MASK;
            r_mask  <= MSB_MASK;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_CMP: begin
          if (!abort) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_onehot) r_err <= 1'b1;
            if (w_hit) begin
              r_result <= r_trial;
              r_steps  <= r_cnt + 1'b1;
            end else begin
              r_mask  <= w_mask_nx;
              r_trial <= w_acc_nx | w_mask_nx;
              if (w_last) begin
                r_result <= w_acc_nx;
                r_steps  <= r_cnt + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign trial  = r_trial;
  assign result = r_result;
  assign steps  = r_steps;
  assign err    = r_err;

endmodule

// File: tb/tb_sar_compare_ctrl.sv
// tb/tb_sar_compare_ctrl.sv - randomized self-checking bench for sar_compare_ctrl
module tb_sar_compare_ctrl;
  localparam int W  = 4;
  localparam int SW = $clog2(W + 1);
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  target = '0;
  logic          frc = 1'b0;
  logic          cmp_lt, cmp_eq, cmp_gt;
  logic [W-1:0]  trial, result;
  logic [SW-1:0] steps;
  logic          busy, done, err;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_tr[W];
  int           exp_n;
  logic [W-1:0] exp_res;
  bit           exp_err;
  logic [W-1:0] prev_res   = '0;
  int           prev_steps = 0;

  // Behavioural comparator; frc injects the illegal eq+gt pattern.
  assign cmp_lt = frc ? 1'b0 : (trial < target);
  assign cmp_eq = frc ? 1'b1 : (trial == target);
  assign cmp_gt = frc ? 1'b1 : (trial > target);

  always #5 clk = ~clk;

  sar_compare_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .trial(trial), .busy(busy), .done(done), .result(result),
    .steps(steps), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Binary search by bit weight: set a bit, keep it if the code does not exceed the target.
  task automatic model(input logic [W-1:0] tgt, input int force_at);
    logic [W-1:0] r;
    logic [W-1:0] t;
    r = '0;
    exp_n = 0;
    exp_err = 1'b0;
    for (int b = W - 1; b >= 0; b--) begin
      t = r | (W'(1) << b);
      exp_tr[exp_n] = t;
      exp_n++;
      if (exp_n == force_at) begin
        exp_err = 1'b1;
      end else begin
        if (t <= tgt) r = t;
        if (EARLY && t == tgt) break;
      end
    end
    exp_res = r;
  endtask

  task automatic run(input logic [W-1:0] tgt, input int force_at, input int abort_at);
    model(tgt, force_at);
    target = tgt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_clr", err, 0);
    for (int k = 1; k <= exp_n; k++) begin
      check("trial", trial, exp_tr[k-1]);
      check("busy", busy, 1);
      frc   = (k == force_at);
      abort = (k == abort_at);
      start = (k > 1) && (k != abort_at);
      @(negedge clk);
      frc = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      if (k == abort_at) begin
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_res", result, prev_res);
        check("abort_steps", steps, prev_steps);
        @(negedge clk);
        check("abort_idle", busy, 0);
        return;
      end
    end
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("result", result, exp_res);
    check("steps", steps, exp_n);
    check("err", err, exp_err);
    check("trial_hold", trial, exp_res);
    prev_res = exp_res;
    prev_steps = exp_n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("err_sticky", err, exp_err);
  endtask

  initial begin
    int fa, ab;
    logic [W-1:0] tg;
    repeat (2) @(negedge clk);
    check("rst_trial", trial, 0);
    check("rst_result", result, 0);
    check("rst_steps", steps, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(4'b1011, 0, 0);
    run(4'b0000, 0, 0);
    run(4'b1111, 0, 0);
    run(4'b0101, 0, 3);
    run(4'b0101, 0, 0);
    run(4'b1000, 0, 0);
    run(4'b0110, 0, 0);
    run(4'b1011, 2, 0);
    run(4'b0011, 0, 0);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", busy, 0);
    @(negedge clk);
    check("start_abort_idle2", busy, 0);

    // Asynchronous reset in the middle of a search that has already raised err.
    model(4'b1101, 1);
    target = 4'b1101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frc = 1'b1;
    @(negedge clk);
    frc = 1'b0;
    start = 1'b1;
    check("pre_rst_err", err, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_trial", trial, 0);
    check("arst_result", result, 0);
    check("arst_steps", steps, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", done, 0);
    prev_res = '0;
    prev_steps = 0;

    for (int i = 0; i < 60; i++) begin
      tg = W'($urandom);
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W)) : 0;
      run(tg, fa, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
